mem_access_ctrl: RTL and testbench

//  Initiator side of the byte-addressed unified memory port used by the multicycle core.
//  - Accepts load/store requests from the core over a valid/ready handshake.
//  - Drives address/writeData/memRead/memWrite to the memory and returns data to the core.
//  - Loads of byte, halfword and word, sign- or zero-extended.
//  - Stores of byte, halfword and word. Sub-word stores use read-modify-write, because the memory writes full words only.

---
 rtl/mem_access_ctrl_pkg.sv | 35 +++
 rtl/mem_access_ctrl_if.sv | 46 ++++
 rtl/mem_access_ctrl_lane_unit.sv | 39 +++
 rtl/mem_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: access size codes,
// FSM state encoding and small address/lane helpers.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_BAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_RSP    = 3'd4
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Bit offset of a little-endian byte lane inside a 32-bit word.
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response channel and memory-side bus of the memory
// access controller; the controller is slave on the core side, master on memory.

// Request channel: a transfer happens at the rising edge where req_valid and
// req_ready are both high; the initiator holds its request fields stable while
// req_valid is high and req_ready is low. rsp_valid is a one-cycle pulse.
interface mem_access_ctrl_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface mem_access_ctrl_mem_if;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;

    modport master (
        output mem_address, mem_write_data, mem_read, mem_write,
        input  mem_data
    );

    modport slave (
        input  mem_address, mem_write_data, mem_read, mem_write,
        output mem_data
    );
endinterface

// File: rtl/mem_access_ctrl_lane_unit.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges byte/half store data into a word for read-modify-write.
module mem_lane_unit
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [31:0] shifted;

    assign shifted = rd_word_i >> lane_shift(lane_i);

    always_comb begin
        load_data_o = shifted;
        case (size_i)
            SZ_B: load_data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: load_data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data_o = shifted;
        endcase
    end

    always_comb begin
        merge_data_o = rd_word_i;
        case (size_i)
            SZ_B:    merge_data_o[lane_shift(lane_i) +: 8] = wdata_i[7:0];
            SZ_H:    merge_data_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the byte-addressed unified memory port: sized loads with
// extension, word stores, and read-modify-write for byte/half stores.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 256,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_access_ctrl_core_if.slave  core,
    mem_access_ctrl_mem_if.master  mem,
    output state_e                 dbg_state_o
);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        rsp_valid_q;

    logic [31:0] eff_addr;
    logic [32:0] end_addr;
    logic        misalign;
    logic        illegal;
    logic [31:0] load_d;
    logic [31:0] merge_d;
    logic        strobe_rd;
    logic        strobe_wr;

    // With alignment checking off, the low address bits are dropped rather than faulted.
    always_comb begin
        eff_addr = core.req_addr;
        if (!CHECK_ALIGN) begin
            if (core.req_size == SZ_H)      eff_addr[0]   = 1'b0;
            else if (core.req_size == SZ_W) eff_addr[1:0] = 2'b00;
        end
    end

    assign misalign = CHECK_ALIGN &&
                      (((core.req_size == SZ_H) && core.req_addr[0]) ||
                       ((core.req_size == SZ_W) && (core.req_addr[1:0] != 2'b00)));
    assign end_addr = {1'b0, eff_addr} + {30'h0, size_bytes(core.req_size)};
    assign illegal  = (core.req_size == SZ_BAD) || misalign || (end_addr > 33'(MEM_BYTES));

    mem_lane_unit u_lane (
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .lane_i       (addr_q[1:0]),
        .rd_word_i    (mem.mem_data),
        .wdata_i      (wdata_q),
        .load_data_o  (load_d),
        .merge_data_o (merge_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            merge_q     <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (core.req_valid) begin
                        addr_q  <= eff_addr;
                        wdata_q <= core.req_wdata;
                        size_q  <= core.req_size;
                        uns_q   <= core.req_unsigned;
                        if (illegal) begin
                            state_q     <= ST_RSP;
                            rdata_q     <= 32'h0;
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                        end else if (!core.req_write) begin
                            state_q    <= ST_RD;
                            mem_read_q <= 1'b1;
                        end else if (core.req_size == SZ_W) begin
                            state_q     <= ST_WR;
                            merge_q     <= core.req_wdata;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= ST_RMW_RD;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    state_q     <= ST_RSP;
                    mem_read_q  <= 1'b0;
                    rdata_q     <= load_d;
                    err_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end
                ST_RMW_RD: begin
                    state_q     <= ST_WR;
                    mem_read_q  <= 1'b0;
                    merge_q     <= merge_d;
                    mem_write_q <= 1'b1;
                end
                ST_WR: begin
                    state_q     <= ST_RSP;
                    mem_write_q <= 1'b0;
                    rdata_q     <= 32'h0;
                    err_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end
                ST_RSP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Reset low forces the bus and handshake quiet even in the cycle it arrives.
    assign strobe_rd = reset && mem_read_q;
    assign strobe_wr = reset && mem_write_q;

    assign mem.mem_read       = strobe_rd;
    assign mem.mem_write      = strobe_wr;
    assign mem.mem_address    = (strobe_rd || strobe_wr) ? word_addr(addr_q) : 32'h0;
    assign mem.mem_write_data = strobe_wr ? merge_q : 32'h0;

    assign core.req_ready = reset && (state_q == ST_IDLE);
    assign core.rsp_valid = reset && rsp_valid_q;
    assign core.rsp_rdata = rdata_q;
    assign core.rsp_err   = err_q;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of single requests, plus
// reset, reset-abort and back-to-back handshake sequences against a byte memory.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int W = 33;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_core_if core_if ();
  mem_access_ctrl_mem_if  mem_if ();
  state_e dbg_state;

  mem_access_ctrl #(.MEM_BYTES(256), .CHECK_ALIGN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .core        (core_if),
    .mem         (mem_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'h0;
  logic [31:0] pre_data = 32'h0;
  logic [7:0]  ridx;

  assign ridx = {mem_if.mem_address[7:2], 2'b00};
  assign mem_if.mem_data = {mem[ridx + 8'd3], mem[ridx + 8'd2], mem[ridx + 8'd1], mem[ridx]};

  always @(posedge clk) begin
    if (mem_if.mem_write) begin
      mem[ridx]        <= mem_if.mem_write_data[7:0];
      mem[ridx + 8'd1] <= mem_if.mem_write_data[15:8];
      mem[ridx + 8'd2] <= mem_if.mem_write_data[23:16];
      mem[ridx + 8'd3] <= mem_if.mem_write_data[31:24];
    end else if (pre_we) begin
      mem[pre_addr]        <= pre_data[7:0];
      mem[pre_addr + 8'd1] <= pre_data[15:8];
      mem[pre_addr + 8'd2] <= pre_data[23:16];
      mem[pre_addr + 8'd3] <= pre_data[31:24];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [W-1:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected response %h expected none", name,
               {core_if.rsp_err, core_if.rsp_rdata});
    end else begin
      exp = exp_q.pop_front();
      check(name, {core_if.rsp_err, core_if.rsp_rdata}, exp);
    end
  endtask

  // Bus invariants, checked every cycle away from the clock edge.
  always @(negedge clk) begin
    checks++;
    if ((mem_if.mem_read && mem_if.mem_write) ||
        (!mem_if.mem_read && !mem_if.mem_write &&
         (mem_if.mem_address != 32'h0 || mem_if.mem_write_data != 32'h0)) ||
        (core_if.rsp_valid && core_if.req_ready) ||
        (!reset && (core_if.req_ready || mem_if.mem_read || mem_if.mem_write))) begin
      errors++;
      $display("FAIL bus_invariant: got rd=%b wr=%b addr=%h wd=%h rdy=%b rsp=%b rst=%b expected exclusive strobes, quiet idle bus",
               mem_if.mem_read, mem_if.mem_write, mem_if.mem_address, mem_if.mem_write_data,
               core_if.req_ready, core_if.rsp_valid, reset);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic apply_req(input vec_t v);
    core_if.req_valid    = 1'b1;
    core_if.req_write    = v.wr;
    core_if.req_size     = v.size;
    core_if.req_unsigned = v.uns;
    core_if.req_addr     = v.addr;
    core_if.req_wdata    = v.wdata;
  endtask

  task automatic do_req(input vec_t v, output int lat, output int nrd, output int nwr,
                        output logic [31:0] maddr, output logic [31:0] mwdata);
    int w;
    lat = 0; nrd = 0; nwr = 0; maddr = 32'h0; mwdata = 32'h0;
    @(negedge clk);
    apply_req(v);
    w = 0;
    while (!core_if.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!core_if.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
    @(posedge clk);
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) core_if.req_valid = 1'b0;
      if (mem_if.mem_read) begin
        nrd++;
        maddr = mem_if.mem_address;
      end
      if (mem_if.mem_write) begin
        nwr++;
        maddr = mem_if.mem_address;
        mwdata = mem_if.mem_write_data;
      end
      if (core_if.rsp_valid) begin
        lat = c;
        sb_check($sformatf("addr %0d response", v.addr));
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 10 cycles");
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[22];
  vec_t bb[4];

  initial begin
    int lat, nrd, nwr, cnt_wr, cnt_rsp, acc, rsps, idx;
    logic [31:0] maddr, mwdata;
    logic busy, just_acc, rdy;

    core_if.req_valid = 1'b0;
    core_if.req_write = 1'b0;
    core_if.req_size = SZ_W;
    core_if.req_unsigned = 1'b0;
    core_if.req_addr = 32'h0;
    core_if.req_wdata = 32'h0;

    //          wr    size    uns   addr        wdata         rdata         err lat rd wr maddr       mwdata
    vecs[0]  = '{1'b0, SZ_W,   1'b0, 32'd140,    32'h0,        32'h00000052, 1'b0, 2, 1, 0, 32'd140, 32'h0};
    vecs[1]  = '{1'b1, SZ_W,   1'b0, 32'd160,    32'h000080FF, 32'h0,        1'b0, 2, 0, 1, 32'd160, 32'h000080FF};
    vecs[2]  = '{1'b0, SZ_B,   1'b0, 32'd160,    32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0, 32'd160, 32'h0};
    vecs[3]  = '{1'b0, SZ_B,   1'b1, 32'd161,    32'h0,        32'h00000080, 1'b0, 2, 1, 0, 32'd160, 32'h0};
    vecs[4]  = '{1'b0, SZ_H,   1'b0, 32'd160,    32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0, 32'd160, 32'h0};
    vecs[5]  = '{1'b0, SZ_H,   1'b1, 32'd160,    32'h0,        32'h000080FF, 1'b0, 2, 1, 0, 32'd160, 32'h0};
    vecs[6]  = '{1'b1, SZ_H,   1'b0, 32'd162,    32'hABCD1234, 32'h0,        1'b0, 3, 1, 1, 32'd160, 32'h123480FF};
    vecs[7]  = '{1'b0, SZ_W,   1'b0, 32'd160,    32'h0,        32'h123480FF, 1'b0, 2, 1, 0, 32'd160, 32'h0};
    vecs[8]  = '{1'b0, SZ_W,   1'b0, 32'd142,    32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,   32'h0};
    vecs[9]  = '{1'b0, SZ_W,   1'b0, 32'd256,    32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,   32'h0};
    vecs[10] = '{1'b0, SZ_BAD, 1'b0, 32'd0,      32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,   32'h0};
    vecs[11] = '{1'b0, SZ_W,   1'b0, 32'd252,    32'h0,        32'hCAFEF00D, 1'b0, 2, 1, 0, 32'd252, 32'h0};
    vecs[12] = '{1'b0, SZ_H,   1'b0, 32'd255,    32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,   32'h0};
    vecs[13] = '{1'b0, SZ_B,   1'b0, 32'd255,    32'h0,        32'hFFFFFFCA, 1'b0, 2, 1, 0, 32'd252, 32'h0};
    vecs[14] = '{1'b0, SZ_B,   1'b1, 32'd254,    32'h0,        32'h000000FE, 1'b0, 2, 1, 0, 32'd252, 32'h0};
    vecs[15] = '{1'b0, SZ_H,   1'b0, 32'd254,    32'h0,        32'hFFFFCAFE, 1'b0, 2, 1, 0, 32'd252, 32'h0};
    vecs[16] = '{1'b1, SZ_B,   1'b0, 32'd253,    32'hDEADBE77, 32'h0,        1'b0, 3, 1, 1, 32'd252, 32'hCAFE770D};
    vecs[17] = '{1'b0, SZ_W,   1'b0, 32'd252,    32'h0,        32'hCAFE770D, 1'b0, 2, 1, 0, 32'd252, 32'h0};
    vecs[18] = '{1'b1, SZ_B,   1'b0, 32'd256,    32'h55,       32'h0,        1'b1, 1, 0, 0, 32'h0,   32'h0};
    vecs[19] = '{1'b1, SZ_W,   1'b0, 32'd254,    32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h0,   32'h0};
    vecs[20] = '{1'b0, SZ_W,   1'b0, 32'hFFFFFFFC, 32'h0,      32'h0,        1'b1, 1, 0, 0, 32'h0,   32'h0};
    vecs[21] = '{1'b1, SZ_H,   1'b0, 32'd254,    32'h99995555, 32'h0,        1'b0, 3, 1, 1, 32'd252, 32'h5555770D};

    bb[0] = '{1'b0, SZ_W,   1'b0, 32'd160, 32'h0, 32'h123480FF, 1'b0, 0, 0, 0, 32'h0, 32'h0};
    bb[1] = '{1'b0, SZ_H,   1'b1, 32'd162, 32'h0, 32'h00001234, 1'b0, 0, 0, 0, 32'h0, 32'h0};
    bb[2] = '{1'b0, SZ_BAD, 1'b0, 32'd160, 32'h0, 32'h0,        1'b1, 0, 0, 0, 32'h0, 32'h0};
    bb[3] = '{1'b0, SZ_B,   1'b1, 32'd164, 32'h0, 32'h000000DD, 1'b0, 0, 0, 0, 32'h0, 32'h0};

    // Reset: hold a request during reset; nothing must be accepted.
    core_if.req_valid = 1'b1;
    preload(8'd140, 32'h00000052);
    preload(8'd252, 32'hCAFEF00D);
    preload(8'd164, 32'hAABBCCDD);
    check("reset_req_ready", W'(core_if.req_ready), W'(0));
    check("reset_mem_read", W'(mem_if.mem_read), W'(0));
    core_if.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_rsp", {core_if.rsp_err, core_if.rsp_rdata}, W'(0));
    check("post_reset_rsp_valid", W'(core_if.rsp_valid), W'(0));
    check("post_reset_ready", W'(core_if.req_ready), W'(1));
    check("post_reset_state", W'(dbg_state), W'(ST_IDLE));

    // Table-driven single requests.
    for (int i = 0; i < 22; i++) begin
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
      do_req(vecs[i], lat, nrd, nwr, maddr, mwdata);
      check($sformatf("v%0d latency", i), W'(lat), W'(vecs[i].exp_lat));
      check($sformatf("v%0d mem_read_cycles", i), W'(nrd), W'(vecs[i].exp_rd));
      check($sformatf("v%0d mem_write_cycles", i), W'(nwr), W'(vecs[i].exp_wr));
      if (vecs[i].exp_rd + vecs[i].exp_wr > 0)
        check($sformatf("v%0d mem_address", i), W'(maddr), W'(vecs[i].exp_maddr));
      if (vecs[i].exp_wr > 0)
        check($sformatf("v%0d mem_write_data", i), W'(mwdata), W'(vecs[i].exp_wdata));
    end
    check("hold_after_rsp", {core_if.rsp_err, core_if.rsp_rdata}, W'(0));

    // Reset arriving at the edge that ends RMW_RD aborts the byte store.
    @(negedge clk);
    apply_req('{1'b1, SZ_B, 1'b0, 32'd165, 32'h11, 32'h0, 1'b0, 0, 0, 0, 32'h0, 32'h0});
    @(posedge clk);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    check("abort_in_rmw_rd", W'(dbg_state), W'(ST_RMW_RD));
    check("abort_rmw_mem_read", W'(mem_if.mem_read), W'(1));
    reset = 1'b0;
    cnt_wr = 0;
    cnt_rsp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_if.mem_write) cnt_wr++;
      if (core_if.rsp_valid) cnt_rsp++;
    end
    check("abort_state_idle", W'(dbg_state), W'(ST_IDLE));
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", W'(core_if.req_ready), W'(1));
    if (mem_if.mem_write) cnt_wr++;
    if (core_if.rsp_valid) cnt_rsp++;
    check("abort_no_mem_write", W'(cnt_wr), W'(0));
    check("abort_no_rsp_valid", W'(cnt_rsp), W'(0));
    exp_q.push_back({1'b0, 32'hAABBCCDD});
    do_req('{1'b0, SZ_W, 1'b0, 32'd164, 32'h0, 32'h0, 1'b0, 0, 0, 0, 32'h0, 32'h0},
           lat, nrd, nwr, maddr, mwdata);
    check("abort_reload_latency", W'(lat), W'(2));

    // Back-to-back requests with req_valid held high.
    acc = 0; rsps = 0; idx = 0; busy = 1'b0; just_acc = 1'b0;
    @(negedge clk);
    apply_req(bb[0]);
    for (int c = 0; c < 30; c++) begin
      rdy = core_if.req_ready;
      if (busy) check($sformatf("bb_ready_low_c%0d", c), W'(rdy), W'(0));
      if (core_if.rsp_valid) begin
        rsps++;
        sb_check($sformatf("bb_rsp%0d", rsps));
        busy = 1'b0;
      end
      if (just_acc) begin
        just_acc = 1'b0;
        idx++;
        if (idx < 4) apply_req(bb[idx]);
        else core_if.req_valid = 1'b0;
      end
      if (rdy && core_if.req_valid) begin
        acc++;
        exp_q.push_back({bb[idx].exp_err, bb[idx].exp_rdata});
        busy = 1'b1;
        just_acc = 1'b1;
      end
      @(negedge clk);
    end
    check("bb_accepted", W'(acc), W'(4));
    check("bb_responses", W'(rsps), W'(4));
    check("scoreboard_drained", W'(exp_q.size()), W'(0));

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
